sccb_init_seq: RTL and testbench

- Sequencer that owns the SCCB register-write controller and drives the camera power-up register table into the sensor.
- Walks a synchronous-read ROM of register writes.
- For each entry, holds the controller's start until done, then releases start and waits for done to clear.
- Retries entries that fail ACK, inserts programmable delays, and reports completion or failure to the capture pipeline.

---
 rtl/sccb_init_pkg.sv | 24 ++
 rtl/sccb_wait_timer.sv | 29 ++
 rtl/sccb_init_seq.sv | 209 ++++++++++++++++++++
 tb/tb_sccb_init_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_init_pkg.sv
// Shared types and constants for the SCCB power-up register sequencer.
package sccb_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_RELEASE,
    ST_DELAY,
    ST_NEXT,
    ST_FINISH,
    ST_FAIL
  } state_t;

  localparam logic [15:0] ENTRY_END = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG = 8'hFE;
  localparam int          TIMER_W   = 32;

  function automatic logic is_delay(input logic [15:0] entry);
    return entry[15:8] == DELAY_TAG;
  endfunction

endpackage

// File: rtl/sccb_wait_timer.sv
// Loadable down-counter shared by the table delay and the done watchdog.
// expired is high whenever the count has reached zero.
module sccb_wait_timer
  import sccb_init_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sccb_init_seq.sv
// Walks the camera power-up ROM table and feeds register writes to the SCCB controller.
// Optional macro SCCB_READBACK_EN adds a verify-read after every successful write.
module sccb_init_seq
  import sccb_init_pkg::*;
#(
  parameter int          ROM_AW         = 8,
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter int          DELAY_UNIT     = 50000,
  parameter int          MAX_RETRIES    = 3,
  parameter int          TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic [7:0]        sccb_addr_o,
  output logic [15:0]       sccb_data_o,
  output logic              sccb_rw_o,
  output logic              sccb_start_o,
  input  logic              sccb_done_i,
  input  logic              sccb_ack_error_i,
`ifdef SCCB_READBACK_EN
  input  logic [7:0]        sccb_rdata_i,
  output logic              mismatch_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ROM_AW-1:0] err_index_o
);

  localparam logic [TIMER_W-1:0] TIMEOUT_W = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] DELAY_W   = TIMER_W'(DELAY_UNIT);
  localparam logic [7:0]         MAX_R     = 8'(MAX_RETRIES);

  state_t               state;
  logic                 go_q;
  logic                 go_rise;
  logic                 attempt_err;
  logic [7:0]           retries;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_expired;

  assign go_rise     = go_i & ~go_q;
  assign sccb_addr_o = DEV_ADDR;

  // The timer is reloaded on the cycle before ISSUE or DELAY is entered, so
  // it holds the full count on the first cycle of either state.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = TIMEOUT_W;
    if (state == ST_DECODE) begin
      timer_load = 1'b1;
      if (is_delay(rom_data_i)) begin
        timer_value = TIMER_W'(rom_data_i[7:0]) * DELAY_W;
      end
    end else if (state == ST_RELEASE && !sccb_done_i) begin
      timer_load = 1'b1;
    end
  end

  sccb_wait_timer #(.W(TIMER_W)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

`ifdef SCCB_READBACK_EN
  logic rd_phase;
  logic rd_bad;

  assign rd_bad = rd_phase && !sccb_ack_error_i && (sccb_rdata_i != rom_data_i[7:0]);
`else
  assign sccb_rw_o = 1'b1;
`endif

  // Main sequencer; all handshake and status outputs are registered here so
  // an asynchronous reset drops sccb_start_o at once and aborts the controller.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      go_q         <= 1'b0;
      rom_addr_o   <= '0;
      sccb_data_o  <= '0;
      sccb_start_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      err_index_o  <= '0;
      retries      <= '0;
      attempt_err  <= 1'b0;
`ifdef SCCB_READBACK_EN
      sccb_rw_o    <= 1'b1;
      rd_phase     <= 1'b0;
      mismatch_o   <= 1'b0;
`endif
    end else begin
      go_q <= go_i;
      case (state)
        ST_IDLE: begin
          if (go_rise) begin
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            err_index_o <= '0;
            rom_addr_o  <= '0;
            busy_o      <= 1'b1;
`ifdef SCCB_READBACK_EN
            mismatch_o  <= 1'b0;
`endif
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (rom_data_i == ENTRY_END) begin
            state <= ST_FINISH;
          end else if (is_delay(rom_data_i)) begin
            state <= ST_DELAY;
          end else begin
            sccb_data_o  <= rom_data_i;
            retries      <= '0;
            sccb_start_o <= 1'b1;
`ifdef SCCB_READBACK_EN
            sccb_rw_o    <= 1'b1;
            rd_phase     <= 1'b0;
`endif
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sccb_done_i) begin
`ifdef SCCB_READBACK_EN
            attempt_err <= sccb_ack_error_i | rd_bad;
            if (rd_bad) mismatch_o <= 1'b1;
`else
            attempt_err <= sccb_ack_error_i;
`endif
            sccb_start_o <= 1'b0;
            state        <= ST_RELEASE;
          end else if (timer_expired) begin
            attempt_err  <= 1'b1;
            sccb_start_o <= 1'b0;
            state        <= ST_RELEASE;
          end
        end
        // Controller clears done on its own schedule; only then is it safe to
        // decide between moving on, retrying or giving up.
        ST_RELEASE: begin
          if (!sccb_done_i) begin
            if (!attempt_err) begin
`ifdef SCCB_READBACK_EN
              if (!rd_phase) begin
                rd_phase     <= 1'b1;
                sccb_rw_o    <= 1'b0;
                sccb_start_o <= 1'b1;
                state        <= ST_ISSUE;
              end else begin
                rd_phase  <= 1'b0;
                sccb_rw_o <= 1'b1;
                state     <= ST_NEXT;
              end
`else
              state <= ST_NEXT;
`endif
            end else if (retries < MAX_R) begin
              retries      <= retries + 8'd1;
              sccb_start_o <= 1'b1;
`ifdef SCCB_READBACK_EN
              rd_phase     <= 1'b0;
              sccb_rw_o    <= 1'b1;
`endif
              state        <= ST_ISSUE;
            end else begin
              state <= ST_FAIL;
            end
          end
        end
        ST_DELAY: begin
          if (timer_expired) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (rom_addr_o == '1) begin
            state <= ST_FINISH;
          end else begin
            rom_addr_o <= rom_addr_o + 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_FAIL: begin
          error_o     <= 1'b1;
          err_index_o <= rom_addr_o;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Scoreboard bench for sccb_init_seq: ROM and SCCB controller models, expected
// register writes queued per pass and matched against every rising sccb_start_o.
module tb_sccb_init_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        go_i;
  logic [7:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic [7:0]  sccb_addr_o;
  logic [15:0] sccb_data_o;
  logic        sccb_rw_o;
  logic        sccb_start_o;
  logic        sccb_done_i;
  logic        sccb_ack_error_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  err_index_o;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int goCycle, passCycles, lastStartCycle, startCount;
  logic startPrev = 1'b0;
  logic [15:0] rom [256];
  logic [15:0] expQ [$];
  int nackAddr, nackTimes;
  bit neverDone;

  sccb_init_seq #(
    .ROM_AW(8), .DEV_ADDR(8'h42), .DELAY_UNIT(10),
    .MAX_RETRIES(3), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .sccb_addr_o(sccb_addr_o), .sccb_data_o(sccb_data_o),
    .sccb_rw_o(sccb_rw_o), .sccb_start_o(sccb_start_o),
    .sccb_done_i(sccb_done_i), .sccb_ack_error_i(sccb_ack_error_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_index_o(err_index_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle <= cycle + 1;
  always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

  // Controller model: done a few cycles after start, cleared a few cycles after
  // start drops; NACKs the chosen entry nackTimes per pass.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_CLR} mstate_t;
  mstate_t mState;
  int mCnt, mNacked;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mState <= M_IDLE; mCnt <= 0; mNacked <= 0;
      sccb_done_i <= 1'b0; sccb_ack_error_i <= 1'b0;
    end else begin
      if (go_i) mNacked <= 0;
      case (mState)
        M_IDLE: if (sccb_start_o && !neverDone) begin mCnt <= 5; mState <= M_RUN; end
        M_RUN: begin
          if (mCnt == 0) begin
            sccb_done_i <= 1'b1;
            if (int'(rom_addr_o) == nackAddr && mNacked < nackTimes) begin
              sccb_ack_error_i <= 1'b1;
              mNacked <= mNacked + 1;
            end else begin
              sccb_ack_error_i <= 1'b0;
            end
            mState <= M_HOLD;
          end else mCnt <= mCnt - 1;
        end
        M_HOLD: if (!sccb_start_o) begin mCnt <= 4; mState <= M_CLR; end
        M_CLR: begin
          if (mCnt == 0) begin
            sccb_done_i <= 1'b0; sccb_ack_error_i <= 1'b0; mState <= M_IDLE;
          end else mCnt <= mCnt - 1;
        end
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One negedge step; also scores every new controller start.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk_i);
    if (sccb_start_o && !startPrev) begin
      startCount++;
      lastStartCycle = cycle;
      if (expQ.size() == 0) begin
        checkOutput("unexpected start", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sccb_data_o", 32'(sccb_data_o), 32'(e));
      end
      checkOutput("sccb_addr_o", 32'(sccb_addr_o), 32'h42);
      checkOutput("sccb_rw_o", 32'(sccb_rw_o), 32'd1);
    end
    startPrev = sccb_start_o;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic applyStimulus(input int maxCycles, input bit busyPulse);
    int n;
    goCycle = cycle;
    go_i = 1'b1; tick(); tick(); go_i = 1'b0;
    n = 0;
    while (!busy_o && n < 10) begin tick(); n++; end
    checkOutput("busy_o rises", 32'(busy_o), 32'd1);
    checkOutput("done_o cleared", 32'(done_o), 32'd0);
    checkOutput("error_o cleared", 32'(error_o), 32'd0);
    if (busyPulse) begin
      repeat (5) tick();
      go_i = 1'b1; tick(); go_i = 1'b0;
    end
    n = 0;
    while (busy_o && n < maxCycles) begin tick(); n++; end
    checkOutput("pass ends", 32'(busy_o), 32'd0);
    passCycles = cycle - goCycle;
  endtask

  task automatic checkPassEnd(input logic expDone, input logic expErr, input logic [7:0] expIdx);
    checkOutput("done_o", 32'(done_o), 32'(expDone));
    checkOutput("error_o", 32'(error_o), 32'(expErr));
    checkOutput("err_index_o", 32'(err_index_o), 32'(expIdx));
    checkOutput("starts left", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int n, s0;
    rst_i = 1'b1; go_i = 1'b0; neverDone = 1'b0; nackAddr = -1; nackTimes = 0;
    startCount = 0; lastStartCycle = 0;
    clearRom();
    tick(); tick();
    checkOutput("reset sccb_start_o", 32'(sccb_start_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset done_o", 32'(done_o), 32'd0);
    checkOutput("reset error_o", 32'(error_o), 32'd0);
    checkOutput("reset rom_addr_o", 32'(rom_addr_o), 32'd0);
    checkOutput("reset sccb_data_o", 32'(sccb_data_o), 32'd0);
    checkOutput("reset err_index_o", 32'(err_index_o), 32'd0);
    checkOutput("reset sccb_addr_o", 32'(sccb_addr_o), 32'h42);
    checkOutput("reset sccb_rw_o", 32'(sccb_rw_o), 32'd1);
    rst_i = 1'b0;
    tick();

    $display("[TB] two writes, go pulsed mid-pass");
    rom[0] = 16'h1280; rom[1] = 16'h1100;
    expQ.push_back(16'h1280); expQ.push_back(16'h1100);
    s0 = startCount;
    applyStimulus(500, 1'b1);
    checkPassEnd(1'b1, 1'b0, 8'd0);
    checkOutput("start count", 32'(startCount - s0), 32'd2);

    $display("[TB] delay entries before a write");
    clearRom();
    rom[0] = 16'hFE00; rom[1] = 16'hFE02; rom[2] = 16'h1280;
    expQ.push_back(16'h1280);
    applyStimulus(500, 1'b0);
    checkPassEnd(1'b1, 1'b0, 8'd0);
    checkOutput("delay min gap", 32'((lastStartCycle - goCycle) >= 20), 32'd1);
    checkOutput("delay max gap", 32'((lastStartCycle - goCycle) <= 45), 32'd1);

    $display("[TB] entry 1 NACKed twice then ACKed");
    clearRom();
    rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'h1234;
    nackAddr = 1; nackTimes = 2;
    expQ.push_back(16'h1280);
    repeat (3) expQ.push_back(16'h1100);
    expQ.push_back(16'h1234);
    s0 = startCount;
    applyStimulus(1000, 1'b0);
    checkPassEnd(1'b1, 1'b0, 8'd0);
    checkOutput("retry start count", 32'(startCount - s0), 32'd5);

    $display("[TB] entry 2 always NACKed");
    clearRom();
    rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'h2233; rom[3] = 16'h3344;
    nackAddr = 2; nackTimes = 1000;
    expQ.push_back(16'h1280); expQ.push_back(16'h1100);
    repeat (4) expQ.push_back(16'h2233);
    s0 = startCount;
    applyStimulus(1000, 1'b0);
    checkPassEnd(1'b0, 1'b1, 8'd2);
    checkOutput("fail start count", 32'(startCount - s0), 32'd6);
    nackAddr = -1; nackTimes = 0;

    $display("[TB] controller never answers");
    clearRom();
    rom[0] = 16'h1280;
    neverDone = 1'b1;
    repeat (4) expQ.push_back(16'h1280);
    s0 = startCount;
    applyStimulus(2000, 1'b0);
    checkPassEnd(1'b0, 1'b1, 8'd0);
    checkOutput("timeout start count", 32'(startCount - s0), 32'd4);
    checkOutput("timeout duration", 32'(passCycles >= 400 && passCycles <= 440), 32'd1);
    neverDone = 1'b0;

    $display("[TB] reset during a transaction");
    expQ.push_back(16'h1280); expQ.push_back(16'h1280);
    go_i = 1'b1; tick(); tick(); go_i = 1'b0;
    n = 0;
    while (!sccb_start_o && n < 50) begin tick(); n++; end
    checkOutput("start before reset", 32'(sccb_start_o), 32'd1);
    #2 rst_i = 1'b1;
    #1 checkOutput("async start drop", 32'(sccb_start_o), 32'd0);
    checkOutput("async busy drop", 32'(busy_o), 32'd0);
    tick(); rst_i = 1'b0;
    tick();
    checkOutput("addr after reset", 32'(rom_addr_o), 32'd0);
    applyStimulus(500, 1'b0);
    checkPassEnd(1'b1, 1'b0, 8'd0);

    $display("[TB] full table with no end marker");
    for (int i = 0; i < 256; i++) begin
      rom[i] = {8'h10, 8'(i)};
      expQ.push_back({8'h10, 8'(i)});
    end
    s0 = startCount;
    applyStimulus(10000, 1'b0);
    checkPassEnd(1'b1, 1'b0, 8'd0);
    checkOutput("full start count", 32'(startCount - s0), 32'd256);
    checkOutput("top address held", 32'(rom_addr_o), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
